// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - opcode constants, FSM state encoding and pc helper for the accumulator core
package acc_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_CLR = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LDA = 4'h3;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Program counter after retiring op at pc; the 4-bit add wraps 15 -> 0.
    function automatic logic [3:0] next_pc(input logic [3:0] op,
                                           input logic [3:0] pc,
                                           input logic [3:0] target);
        if (op == OP_JMP) begin
            return target;
        end else if (op == OP_HLT) begin
            return pc;
        end else begin
            return pc + 4'd1;
        end
    endfunction

endpackage

// File: rtl/acc_alu.sv
// rtl/acc_alu.sv - combinational opcode-to-{acc,carry} datapath
module acc_alu
    import acc_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] acc,
    input  logic       carry,
    input  logic [7:0] operand,
    output logic [7:0] acc_next,
    output logic       carry_next
);

    logic [8:0] sum;

    // Unlisted opcodes (NOP, JMP, HLT) fall through with acc and carry untouched.
    always_comb begin
        acc_next   = acc;
        carry_next = carry;
        sum        = 9'd0;
        case (op)
            OP_CLR: begin
                acc_next   = 8'h00;
                carry_next = 1'b0;
            end
            OP_ADD: begin
                sum        = {1'b0, acc} + {1'b0, operand};
                acc_next   = sum[7:0];
                carry_next = sum[8];
            end
            OP_SUB: begin
                acc_next   = acc - operand;
                carry_next = (operand > acc);
            end
            OP_LDA: acc_next = operand;
            OP_AND: acc_next = acc & operand;
            OP_OR:  acc_next = acc | operand;
            OP_NOT: acc_next = ~acc;
            OP_XOR: acc_next = acc ^ operand;
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_fetch_exec.sv
// rtl/acc_fetch_exec.sv - two-cycle fetch/execute accumulator core with halt
module acc_fetch_exec
    import acc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic [3:0] romAddress,
    input  logic [7:0] romData,
    output logic [3:0] ramAddress,
    input  logic [7:0] ramData,
    output logic [7:0] acc,
    output logic [3:0] pc,
    output logic       carry,
    output logic       halted,
    output logic       instrDone
);

    state_t     state, state_d;
    logic [7:0] ir, ir_d;
    logic [7:0] acc_d;
    logic [3:0] pc_d;
    logic       carry_d;
    logic       halted_d;
    logic       done_d;
    logic [7:0] alu_acc;
    logic       alu_carry;

    assign romAddress = pc;
    assign ramAddress = ir[3:0];

    acc_alu u_alu (
        .op         (ir[7:4]),
        .acc        (acc),
        .carry      (carry),
        .operand    (ramData),
        .acc_next   (alu_acc),
        .carry_next (alu_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= 4'd0;
            ir        <= 8'h00;
            acc       <= 8'h00;
            carry     <= 1'b0;
            halted    <= 1'b0;
            instrDone <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            ir        <= ir_d;
            acc       <= acc_d;
            carry     <= carry_d;
            halted    <= halted_d;
            instrDone <= done_d;
        end
    end

    // run only matters in FETCH; once in EXEC the instruction always retires.
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        ir_d     = ir;
        acc_d    = acc;
        carry_d  = carry;
        halted_d = halted;
        done_d   = 1'b0;
        case (state)
            FETCH: begin
                if (run) begin
                    ir_d    = romData;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                acc_d   = alu_acc;
                carry_d = alu_carry;
                pc_d    = next_pc(ir[7:4], pc, ir[3:0]);
                done_d  = 1'b1;
                if (ir[7:4] == OP_HLT) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = FETCH;
                end
            end
            HALT: halted_d = 1'b1;
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_acc_fetch_exec.sv
// tb/tb_acc_fetch_exec.sv - scoreboard bench for acc_fetch_exec against an instruction-level model
module tb_acc_fetch_exec;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] romAddress, ramAddress, pc;
    logic [7:0] romData, ramData, acc;
    logic       carry, halted, instrDone;

    logic [7:0] rom [16];
    logic [7:0] ram [16];

    typedef struct {
        logic [3:0] pc;
        logic [7:0] acc;
        logic       carry;
        logic       halted;
    } exp_t;

    exp_t q[$];
    exp_t fin;
    int tests = 0;
    int fails = 0;

    assign romData = rom[romAddress];
    assign ramData = ram[ramAddress];

    always #5 clk = ~clk;

    acc_fetch_exec dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .romAddress (romAddress),
        .romData    (romData),
        .ramAddress (ramAddress),
        .ramData    (ramData),
        .acc        (acc),
        .pc         (pc),
        .carry      (carry),
        .halted     (halted),
        .instrDone  (instrDone)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction-level reference: one call = one retired instruction.
    task automatic model_step(inout exp_t s);
        int op, a, d, r;
        op = rom[s.pc][7:4];
        a  = rom[s.pc][3:0];
        d  = ram[a];
        r  = s.acc;
        case (op)
            0: begin r = 0; s.carry = 0; end
            1: begin r = r + d; s.carry = (r > 255); r = r % 256; end
            2: begin s.carry = (d > r); r = (r - d + 256) % 256; end
            3: r = d;
            5: r = r & d;
            6: r = r | d;
            7: r = 255 - r;
            8: r = r ^ d;
            default: ;
        endcase
        s.acc = r[7:0];
        if (op == 9) s.pc = a[3:0];
        else if (op == 15) s.halted = 1;
        else s.pc = 4'((s.pc + 1) % 16);
    endtask

    task automatic monitor();
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (instrDone) begin
                    check("done_not_back_to_back", {15'd0, prev_done}, 16'd0);
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_instrDone: got pulse at pc=%h expected none", pc);
                    end else begin
                        e = q.pop_front();
                        check("retire_pc", {12'd0, pc}, {12'd0, e.pc});
                        check("retire_acc", {8'd0, acc}, {8'd0, e.acc});
                        check("retire_carry_halted", {14'd0, carry, halted}, {14'd0, e.carry, e.halted});
                    end
                end
                prev_done = instrDone;
            end else begin
                prev_done = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        run   = 1'b0;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("reset_pc_acc", {4'd0, pc, acc}, 16'd0);
        check("reset_flags", {13'd0, carry, halted, instrDone}, 16'd0);
        check("reset_romaddr", {12'd0, romAddress}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_prog(input int n_max, input int hold, input bit rand_run);
        exp_t s;
        int cyc;
        s = '{pc: 4'd0, acc: 8'd0, carry: 1'b0, halted: 1'b0};
        do_reset();
        for (int i = 0; i < n_max && !s.halted; i++) begin
            model_step(s);
            q.push_back(s);
        end
        fin = s;
        repeat (hold) @(negedge clk);
        if (hold > 0) check("hold_run0_pc_acc", {4'd0, pc, acc}, 16'd0);
        cyc = 0;
        while (cyc < 4000) begin
            @(negedge clk);
            if (q.size() == 0) break;
            run = rand_run ? ($urandom_range(3) != 0) : 1'b1;
            cyc++;
        end
        run = 1'b0;
        if (cyc >= 4000) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d retirements pending expected 0", q.size());
        end
        run = fin.halted;
        repeat (5) @(negedge clk);
        run = 1'b0;
        check("final_pc_acc", {4'd0, pc, acc}, {4'd0, fin.pc, fin.acc});
        check("final_flags", {14'd0, carry, halted}, {14'd0, fin.carry, fin.halted});
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reference program with a halt appended
        foreach (rom[i]) rom[i] = 8'hF0;
        foreach (ram[i]) ram[i] = 8'h00;
        rom[0] = 8'h00; rom[1] = 8'h21; rom[2] = 8'h52; rom[3] = 8'h63;
        rom[4] = 8'h74; rom[5] = 8'h84; rom[6] = 8'h10; rom[7] = 8'hF0;
        ram[0] = 8'h0F; ram[1] = 8'h01; ram[2] = 8'hF0; ram[3] = 8'h3C; ram[4] = 8'hAA;
        run_prog(20, 5, 1'b1);
        check("prog_halt_pc", {12'd0, pc}, 16'd7);

        // ADD overflow: 0xFF + 0x01
        foreach (rom[i]) rom[i] = 8'hF0;
        rom[0] = 8'h30; rom[1] = 8'h11;
        ram[0] = 8'hFF; ram[1] = 8'h01;
        run_prog(10, 0, 1'b0);
        check("add_wrap_acc", {8'd0, acc}, 16'h0000);
        check("add_wrap_carry_halt", {14'd0, carry, halted}, 16'd3);

        // HLT at pc 2
        rom[0] = 8'h00; rom[1] = 8'h21; rom[2] = 8'hF0;
        run_prog(10, 0, 1'b1);
        check("hlt_pc", {12'd0, pc}, 16'd2);

        // JMP loop back to 1
        foreach (rom[i]) rom[i] = 8'hA0;
        rom[0] = 8'h30; rom[1] = 8'h11; rom[2] = 8'h22; rom[3] = 8'h91;
        ram[0] = 8'h05; ram[1] = 8'h07; ram[2] = 8'h03;
        run_prog(13, 0, 1'b1);

        // NOP walk across pc 15 -> 0
        foreach (rom[i]) rom[i] = 8'h40 | 8'(i);
        rom[0] = 8'h31;
        run_prog(18, 0, 1'b1);
        check("wrap_pc", {12'd0, pc}, 16'd2);

        // Random programs
        for (int k = 0; k < 6; k++) begin
            foreach (rom[i]) rom[i] = 8'($urandom);
            foreach (ram[i]) ram[i] = 8'($urandom);
            run_prog(30, k % 2, 1'b1);
        end

        // Reset in the middle of an ADD execute
        foreach (rom[i]) rom[i] = 8'hF0;
        rom[0] = 8'h30; rom[1] = 8'h11;
        ram[0] = 8'h55; ram[1] = 8'h22;
        do_reset();
        q.push_back('{pc: 4'd1, acc: 8'h55, carry: 1'b0, halted: 1'b0});
        run = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midexec_reset_pc_acc", {4'd0, pc, acc}, 16'd0);
        @(posedge clk);
        #1;
        check("midexec_no_update", {4'd0, pc, acc}, 16'd0);
        check("midexec_flags", {13'd0, carry, halted, instrDone}, 16'd0);
        check("midexec_lda_retired", 16'(q.size()), 16'd0);
        @(negedge clk);
        run   = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midexec_after_release", {4'd0, pc, acc}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/acc_fetch_exec.md
ACC_FETCH_EXEC -- requirements
Module: acc_fetch_exec

Interface
REQ-001 SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port run, input, 1, fetch enable; low holds the core in FETCH without advancing.
REQ-004 SHALL have port romAddress, output, 4, instruction ROM address, always equal to pc.
REQ-005 SHALL have port romData, input, 8, ROM instruction word, combinational in romAddress: [7:4] opcode, [3:0] operand address.
REQ-006 SHALL have port ramAddress, output, 4, data memory read address, equal to ir[3:0].
REQ-007 SHALL have port ramData, input, 8, data memory word, combinational in ramAddress.
REQ-008 SHALL have port acc, output, 8, accumulator value.
REQ-009 SHALL have port pc, output, 4, program counter value.
REQ-010 SHALL have port carry, output, 1, carry from ADD or borrow from SUB.
REQ-011 SHALL have port halted, output, 1, high while in HALT.
REQ-012 SHALL have port instrDone, output, 1, one-cycle pulse on the edge that retires an instruction.

Function
REQ-013 SHALL implement FSM states FETCH, EXEC, HALT; every instruction takes exactly 2 cycles (FETCH then EXEC).
REQ-014 In FETCH with run=1, SHALL latch romData into ir and go to EXEC; with run=0, SHALL hold all registers and stay in FETCH.
REQ-015 In EXEC, SHALL update acc/carry from ir and ramData, then return to FETCH with pc=pc+1 (4-bit, 15 wraps to 0) unless stated otherwise.
REQ-016 Opcode 0x0 CLR: acc<=0x00, carry<=0.
REQ-017 Opcode 0x1 ADD: {carry,acc}<=acc+ramData, 9-bit result.
REQ-018 Opcode 0x2 SUB: acc<=acc-ramData mod 256; carry<=1 when ramData>acc, else 0.
REQ-019 Opcode 0x3 LDA: acc<=ramData; carry unchanged.
REQ-020 Opcodes 0x5 AND, 0x6 OR, 0x8 XOR: acc<=acc op ramData bitwise; carry unchanged.
REQ-021 Opcode 0x7 NOT: acc<=~acc; operand ignored; carry unchanged.
REQ-022 Opcode 0x9 JMP: pc<=ir[3:0]; acc and carry unchanged.
REQ-023 Opcode 0xF HLT: pc unchanged; go to HALT; HALT is left only by reset.
REQ-024 Opcodes 0x4 and 0xA-0xE SHALL act as NOP: pc<=pc+1 only.
REQ-025 run SHALL be sampled only in FETCH; deasserting run during EXEC SHALL NOT abort the current instruction.
REQ-026 instrDone SHALL pulse on the EXEC-to-next-state edge for every opcode, HLT included; it SHALL never pulse in FETCH or HALT.
REQ-027 halted SHALL be registered and high from the edge entering HALT.

Reset
REQ-028 rst_n low SHALL immediately force state=FETCH, pc=0, ir=0x00, acc=0x00, carry=0, halted=0, instrDone=0, regardless of clk.
REQ-029 Reset asserted mid-EXEC SHALL discard the instruction in flight with no acc/pc update.
REQ-030 The first fetch after release SHALL be at the first rising clk edge with rst_n=1 and run=1.

Structure
REQ-031 Opcode constants (CLR..HLT) and FSM state encoding SHALL reside in a shared package acc_pkg.
REQ-032 The opcode-to-{acc,carry} datapath SHALL be a combinational sub-module acc_alu; acc_fetch_exec owns the FSM, pc, ir and registers.

Verification
REQ-033 Reset with ROM {00,21,52,63,74,84,10,00} and RAM[0..4]={0F,01,F0,3C,AA}, run=1 -> after 7 instrDone pulses (14 cycles), acc=0xB8, carry=0, pc=7; after instruction 2 (SUB), acc=0xFF and carry=1.
REQ-034 acc=0xFF, ADD with RAM=0x01 -> acc=0x00, carry=1.
REQ-035 ROM[3]=0x91 -> after executing at pc=3, pc=1 and acc unchanged; a NOP at pc=15 -> pc wraps to 0.
REQ-036 run=0 for 5 cycles in FETCH -> pc, acc and ir stable, no instrDone; run=0 during EXEC -> the instruction retires.
REQ-037 ROM[2]=0xF0 -> halted=1 after the third instrDone, pc stays 2, and further clocks with run=1 change nothing.
REQ-038 rst_n pulsed low mid-EXEC of an ADD -> acc=0, pc=0 immediately, with no update on the following edge.
